// File: rtl/agc_pkg.sv
// Shared AGC constants, DC-blocker state encoding and the one-bit-wider-to-sample clip helper.
package agc_pkg;

  localparam int DATA_W     = 8;
  localparam int FRAME_LOG2 = 10;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_t;

  // Clip a DATA_W+1 signed value into DATA_W: overflow shows as the top two bits disagreeing.
  function automatic logic signed [DATA_W-1:0] sat_s9_to_s8(input logic signed [DATA_W:0] x);
    logic signed [DATA_W-1:0] r;
    if (x[DATA_W] != x[DATA_W-1]) begin
      r = x[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      r = x[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/agc_dc_blocker_if.sv
// Sample stream into the DC blocker and corrected stream / debug taps out of it.
interface agc_dc_blocker_if;
  import agc_pkg::*;

  logic signed [DATA_W-1:0] In1;
  logic                     bypass;
  logic signed [DATA_W-1:0] Out;
  logic                     frame_start;
  logic signed [DATA_W-1:0] offset_dbg;

  modport master (
    output In1, bypass,
    input  Out, frame_start, offset_dbg
  );

  modport slave (
    input  In1, bypass,
    output Out, frame_start, offset_dbg
  );
endinterface

// File: rtl/agc_dc_blocker.sv
// Per-frame DC offset estimator and subtractor ahead of the AGC peak detector.
// Mean is taken over 2^FRAME_LOG2 samples; the offset tracks it with a first-order smoother.
module agc_dc_blocker
  import agc_pkg::*;
#(
  parameter int ALPHA_SHIFT = 2
) (
  input  logic              clk,
  input  logic              reset_not,
  agc_dc_blocker_if.slave   io
);

  localparam int ACC_W = DATA_W + FRAME_LOG2;

  logic [FRAME_LOG2-1:0]    cnt_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic signed [ACC_W-1:0]  in_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [DATA_W-1:0] mean;
  logic signed [DATA_W-1:0] offset_reg;
  logic signed [DATA_W-1:0] offset_next;
  logic signed [DATA_W-1:0] offset_run;
  logic signed [DATA_W:0]   offset_ext;
  logic signed [DATA_W:0]   d;
  logic signed [DATA_W:0]   step;
  logic signed [DATA_W:0]   diff;
  logic signed [DATA_W-1:0] out_reg;
  logic                     frame_start_reg;
  logic                     frame_end;
  state_t                   state_reg;
  state_t                   state_next;

  assign frame_end  = &cnt_reg;
  assign in_ext     = {{FRAME_LOG2{io.In1[DATA_W-1]}}, io.In1};
  assign sum        = acc_reg + in_ext;
  // Upper DATA_W bits of the sum are exactly sum >>> FRAME_LOG2 (floor toward -inf).
  assign mean       = sum[FRAME_LOG2 +: DATA_W];
  assign offset_ext = {offset_reg[DATA_W-1], offset_reg};
  assign d          = {mean[DATA_W-1], mean} - offset_ext;
  assign step       = d >>> ALPHA_SHIFT;
  // The smoothed value always lies between offset and mean, so the clip never engages.
  assign offset_run = sat_s9_to_s8(offset_ext + step);
  assign diff       = {io.In1[DATA_W-1], io.In1} - offset_ext;

  always_comb begin
    state_next  = state_reg;
    offset_next = offset_reg;
    if (frame_end) begin
      case (state_reg)
        WARMUP: begin
          offset_next = mean;
          state_next  = RUN;
        end
        RUN: begin
          offset_next = offset_run;
          state_next  = RUN;
        end
        default: begin
          offset_next = mean;
          state_next  = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) begin
      cnt_reg         <= '0;
      acc_reg         <= '0;
      state_reg       <= WARMUP;
      offset_reg      <= '0;
      out_reg         <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      cnt_reg         <= cnt_reg + 1'b1;
      acc_reg         <= frame_end ? '0 : sum;
      state_reg       <= state_next;
      offset_reg      <= offset_next;
      out_reg         <= io.bypass ? io.In1 : sat_s9_to_s8(diff);
      frame_start_reg <= (cnt_reg == '0);
    end
  end

  assign io.Out         = out_reg;
  assign io.frame_start = frame_start_reg;
  assign io.offset_dbg  = offset_reg;

endmodule

// File: tb/tb_agc_dc_blocker.sv
// Directed bench for agc_dc_blocker: table of in-frame vectors plus multi-frame sequences.
module tb_agc_dc_blocker;

  logic clk = 1'b0;
  logic reset_not = 1'b1;

  agc_dc_blocker_if bus ();

  agc_dc_blocker #(.ALPHA_SHIFT(2)) dut (
    .clk       (clk),
    .reset_not (reset_not),
    .io        (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [7:0] in1;
    logic              byp;
    logic signed [7:0] exp_out;
    logic              exp_fs;
  } vec_t;

  vec_t tbl [8];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int v, input logic b);
    bus.In1    = 8'(v);
    bus.bypass = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_not = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_not = 1'b1;
  endtask

  task automatic run_frame(input int v, output int errs);
    errs = 0;
    for (int k = 0; k < 1024; k++) begin
      cyc(v, 1'b0);
      if (bus.Out != 8'(v)) errs++;
    end
  endtask

  initial begin
    int errs, fs_errs, out_errs, v, eo;
    logic b;
    int exp_off [4];

    // Offset is 20 throughout; inputs sum to 8*20 so the frame mean stays 20.
    tbl[0] = '{8'sd20,   1'b0, 8'sd0,    1'b1};
    tbl[1] = '{-8'sd128, 1'b0, -8'sd128, 1'b0};
    tbl[2] = '{8'sd127,  1'b0, 8'sd107,  1'b0};
    tbl[3] = '{8'sd0,    1'b0, -8'sd20,  1'b0};
    tbl[4] = '{8'sd5,    1'b1, 8'sd5,    1'b0};
    tbl[5] = '{-8'sd7,   1'b1, -8'sd7,   1'b0};
    tbl[6] = '{8'sd103,  1'b0, 8'sd83,   1'b0};
    tbl[7] = '{8'sd40,   1'b1, 8'sd40,   1'b0};
    exp_off = '{0, 10, 17, 22};

    bus.In1    = '0;
    bus.bypass = 1'b0;
    #1 reset_not = 1'b0;
    #1;
    check("reset_out", int'(bus.Out), 0);
    check("reset_fs", int'(bus.frame_start), 0);
    check("reset_offset", int'(bus.offset_dbg), 0);
    repeat (2) @(posedge clk);
    #1 reset_not = 1'b1;

    // Constant 20: uncorrected for the warmup frame, zero afterwards.
    errs = 0;
    for (int k = 0; k < 1024; k++) begin
      cyc(20, 1'b0);
      if (k == 0) begin
        check("first_fs", int'(bus.frame_start), 1);
        check("first_out", int'(bus.Out), 20);
      end else if (bus.Out != 8'sd20 || bus.frame_start != 1'b0) begin
        errs++;
      end
      if (k == 1022) check("offset_before_end", int'(bus.offset_dbg), 0);
    end
    check("warmup_out_errs", errs, 0);
    check("warmup_offset", int'(bus.offset_dbg), 20);

    for (int i = 0; i < 8; i++) begin
      cyc(int'(tbl[i].in1), tbl[i].byp);
      $display("vec %0d in=%0d byp=%0d out=%0d fs=%0d", i, tbl[i].in1, tbl[i].byp, bus.Out, bus.frame_start);
      check($sformatf("vec%0d_out", i), int'(bus.Out), int'(tbl[i].exp_out));
      check($sformatf("vec%0d_fs", i), int'(bus.frame_start), int'(tbl[i].exp_fs));
    end
    errs = 0;
    for (int k = 8; k < 1024; k++) begin
      cyc(20, 1'b0);
      if (bus.Out != 8'sd0) errs++;
    end
    check("table_frame_out_errs", errs, 0);
    check("table_frame_offset", int'(bus.offset_dbg), 20);

    // Reset mid-frame at cnt=500.
    for (int k = 0; k < 500; k++) cyc(20, 1'b0);
    #2 reset_not = 1'b0;
    #1;
    check("midreset_out", int'(bus.Out), 0);
    check("midreset_fs", int'(bus.frame_start), 0);
    check("midreset_offset", int'(bus.offset_dbg), 0);
    repeat (3) @(posedge clk);
    #1;
    check("midreset_hold_offset", int'(bus.offset_dbg), 0);
    reset_not = 1'b1;

    // Zero frame (must be WARMUP with clean acc), then 40s; frame 2 in bypass.
    fs_errs  = 0;
    out_errs = 0;
    for (int f = 0; f < 4; f++) begin
      v = (f == 0) ? 0 : 40;
      b = (f == 2);
      eo = (f == 0) ? 0 : (f == 2) ? 40 : 40 - exp_off[f-1];
      for (int k = 0; k < 1024; k++) begin
        cyc(v, b);
        if (int'(bus.frame_start) != ((k == 0) ? 1 : 0)) fs_errs++;
        if (int'(bus.Out) != eo) out_errs++;
      end
      check($sformatf("alpha_offset_f%0d", f), int'(bus.offset_dbg), exp_off[f]);
    end
    check("fs_spacing_errs", fs_errs, 0);
    check("alpha_out_errs", out_errs, 0);
    cyc(40, 1'b0);
    check("alpha_next_out", int'(bus.Out), 18);
    bus.bypass = 1'b0;

    // Floor rounding of a -1 frame sum.
    do_reset();
    for (int k = 0; k < 1024; k++) cyc((k == 1023) ? -1 : 0, 1'b0);
    check("floor_offset", int'(bus.offset_dbg), -1);
    cyc(0, 1'b0);
    check("floor_out", int'(bus.Out), 1);

    // Saturation at both rails.
    do_reset();
    run_frame(100, errs);
    check("pos_frame_out_errs", errs, 0);
    check("pos_offset", int'(bus.offset_dbg), 100);
    cyc(-128, 1'b0);
    check("sat_low", int'(bus.Out), -128);
    cyc(-50, 1'b1);
    check("bypass_out", int'(bus.Out), -50);

    do_reset();
    run_frame(-100, errs);
    check("neg_offset", int'(bus.offset_dbg), -100);
    cyc(127, 1'b0);
    check("sat_high", int'(bus.Out), 127);
    cyc(-128, 1'b0);
    check("neg_offset_sub", int'(bus.Out), -28);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
